// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped read cache.
// The controller and the address splitter both import this package.
package cache_pkg;

   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_INDEX_BITS = 5;
   localparam int DEF_WORD_BITS  = 2;
   localparam int DEF_BYTE_BITS  = 2;
   localparam int DEF_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REFILL_REQ,
      REFILL_WAIT,
      RESPOND,
      FLUSH
   } state_t;

endpackage

// File: rtl/cache_addr_split.sv
// Combinational split of a byte address into tag / line index / word select.
// Fields from the LSB upward: byte offset, word, index, tag.
module cache_addr_split
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int WORD_BITS  = DEF_WORD_BITS,
   parameter int BYTE_BITS  = DEF_BYTE_BITS,
   localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - WORD_BITS - BYTE_BITS
)(
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [TAG_BITS-1:0]   tag,
   output logic [INDEX_BITS-1:0] index,
   output logic [WORD_BITS-1:0]  word_sel
);

   // The byte offset never affects a word-granular read.
   logic unused_byte_off;

   assign tag             = addr[ADDR_WIDTH-1 -: TAG_BITS];
   assign index           = addr[BYTE_BITS+WORD_BITS +: INDEX_BITS];
   assign word_sel        = addr[BYTE_BITS +: WORD_BITS];
   assign unused_byte_off = ^addr[BYTE_BITS-1:0];

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Direct-mapped, read-only cache lookup controller with line refill and flush.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module cache_lookup_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int WORD_BITS  = DEF_WORD_BITS,
   parameter int BYTE_BITS  = DEF_BYTE_BITS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  flush,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_hit,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data,
   output logic                  busy,
   output state_t                dbg_state
);

   localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - WORD_BITS - BYTE_BITS;
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << WORD_BITS;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  flush_pend_q;
   logic [WORD_BITS-1:0]  beat_q;
   logic [LINES-1:0]      valid_q;
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [DATA_WIDTH-1:0] data_mem [LINES][WORDS];

   logic [TAG_BITS-1:0]   a_tag;
   logic [INDEX_BITS-1:0] a_index;
   logic [WORD_BITS-1:0]  a_word;
   logic                  hit, accept, beat_fire, last_beat;

   cache_addr_split #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INDEX_BITS (INDEX_BITS),
      .WORD_BITS  (WORD_BITS),
      .BYTE_BITS  (BYTE_BITS)
   ) u_split (
      .addr     (addr_q),
      .tag      (a_tag),
      .index    (a_index),
      .word_sel (a_word)
   );

   assign hit       = valid_q[a_index] && (tag_mem[a_index] == a_tag);
   assign accept    = req_valid && req_ready;
   assign beat_fire = (state_q == REFILL_WAIT) && mem_rsp_valid;
   assign last_beat = beat_fire && (beat_q == '1);
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         flush_pend_q <= 1'b0;
         beat_q       <= '0;
         valid_q      <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            addr_q <= req_addr;
         if (beat_fire)
            beat_q <= beat_q + WORD_BITS'(1);
         if (state_q == FLUSH)
            valid_q <= '0;
         else if (last_beat)
            valid_q[a_index] <= 1'b1;
         // A flush that arrives while busy is remembered until the next IDLE.
         if (state_q == IDLE && state_d == FLUSH)
            flush_pend_q <= 1'b0;
         else if (flush && state_q != IDLE)
            flush_pend_q <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (beat_fire)
         data_mem[a_index][beat_q] <= mem_rsp_data;
      if (last_beat)
         tag_mem[a_index] <= a_tag;
   end

   always_comb begin
      state_d       = state_q;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_hit      = 1'b0;
      resp_data     = '0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      case (state_q)
         IDLE: begin
            if (flush || flush_pend_q) begin
               state_d = FLUSH;
            end else begin
               req_ready = rst_n;
               if (req_valid && rst_n)
                  state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               resp_valid = 1'b1;
               resp_hit   = 1'b1;
               resp_data  = data_mem[a_index][a_word];
               state_d    = IDLE;
            end else begin
               state_d = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {a_tag, a_index, {(WORD_BITS+BYTE_BITS){1'b0}}};
            if (mem_req_ready)
               state_d = REFILL_WAIT;
         end
         REFILL_WAIT: begin
            if (last_beat)
               state_d = RESPOND;
         end
         RESPOND: begin
            resp_valid = 1'b1;
            resp_data  = data_mem[a_index][a_word];
            state_d    = IDLE;
         end
         FLUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
